// File: rtl/stage3_hart_pc_unit_if.sv
// Fetch handshake and redirect bus between the per-hart PC unit and its neighbours.
// master = PC unit side; slave = fetch/execute/priv side.
interface stage3_hart_pc_unit_if #(
  parameter int NUM_HARTS = 2
);
  localparam int HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  logic              fetch_valid;
  logic              fetch_ready;
  logic [31:0]       fetch_pc;
  logic [HART_W-1:0] fetch_hart;
  logic              br_valid;
  logic [HART_W-1:0] br_hart;
  logic [31:0]       br_pc;
  logic              trap_valid;
  logic [HART_W-1:0] trap_hart;
  logic [31:0]       trap_pc;

  modport master (
    output fetch_valid, fetch_pc, fetch_hart,
    input  fetch_ready, br_valid, br_hart, br_pc, trap_valid, trap_hart, trap_pc
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_hart,
    output fetch_ready, br_valid, br_hart, br_pc, trap_valid, trap_hart, trap_pc
  );
endinterface

// File: rtl/stage3_hart_pc_unit.sv
// Per-hart PC registers with round-robin fetch issue and trap/branch redirects.
// One lane per hart holds the PARKED/ACTIVE FSM and the PC register.
module stage3_hart_pc_lane #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_INCR  = 32'd4
) (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        en,
  input  logic        inc,
  input  logic        br_hit,
  input  logic        trap_hit,
  input  logic [31:0] br_pc,
  input  logic [31:0] trap_pc,
  output logic [31:0] pc,
  output logic        active
);
  typedef enum logic {PARKED = 1'b0, ACTIVE = 1'b1} state_t;
  state_t state_q, state_d;

  always_ff @(posedge gclk) begin
    if (!grst_n) state_q <= PARKED;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PARKED:  if (en)  state_d = ACTIVE;
      ACTIVE:  if (!en) state_d = PARKED;
      default: state_d = PARKED;
    endcase
  end

  always_comb active = (state_q == ACTIVE);

  // trap > branch > sequential; redirects land even while parked
  always_ff @(posedge gclk) begin
    if (!grst_n)       pc <= RESET_PC;
    else if (trap_hit) pc <= {trap_pc[31:2], 2'b00};
    else if (br_hit)   pc <= {br_pc[31:2], 2'b00};
    else if (inc)      pc <= pc + PC_INCR;
  end
endmodule

module stage3_hart_pc_unit #(
  parameter int          NUM_HARTS = 2,
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] PC_INCR   = 32'd4
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [NUM_HARTS-1:0]        hart_enable,
  stage3_hart_pc_unit_if.master       bus,
  output logic [NUM_HARTS-1:0][31:0]  pc,
  output logic [NUM_HARTS-1:0]        hart_active
);
  localparam int HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  logic [HART_W-1:0]    rr_ptr, sel;
  logic                 found, accept;
  logic [NUM_HARTS-1:0] elig, br_hit, trap_hit, inc;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    // out-of-range hart ids never match any lane and are thus ignored
    assign trap_hit[h] = bus.trap_valid && (bus.trap_hart == HART_W'(h));
    assign br_hit[h]   = bus.br_valid && (bus.br_hart == HART_W'(h)) && !trap_hit[h];
    assign elig[h]     = hart_active[h] && !br_hit[h] && !trap_hit[h];
    assign inc[h]      = accept && (sel == HART_W'(h));

    stage3_hart_pc_lane #(.RESET_PC(RESET_PC), .PC_INCR(PC_INCR)) u_lane (
      .gclk    (CLK),
      .grst_n  (nRST),
      .en      (hart_enable[h]),
      .inc     (inc[h]),
      .br_hit  (br_hit[h]),
      .trap_hit(trap_hit[h]),
      .br_pc   (bus.br_pc),
      .trap_pc (bus.trap_pc),
      .pc      (pc[h]),
      .active  (hart_active[h])
    );
  end

  // first eligible hart at or after rr_ptr, wrapping; rr_ptr when none
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (!found && elig[(int'(rr_ptr) + i) % NUM_HARTS]) begin
        found = 1'b1;
        sel   = HART_W'((int'(rr_ptr) + i) % NUM_HARTS);
      end
    end
  end

  assign accept          = found && bus.fetch_ready;
  assign bus.fetch_valid = found;
  assign bus.fetch_hart  = sel;
  assign bus.fetch_pc    = pc[sel];

  always_ff @(posedge CLK) begin
    if (!nRST)       rr_ptr <= '0;
    else if (accept) rr_ptr <= (sel == HART_W'(NUM_HARTS - 1)) ? '0 : sel + 1'b1;
  end
endmodule

// File: tb/tb_stage3_hart_pc_unit.sv
// Directed, table-driven bench for stage3_hart_pc_unit with two harts.
module tb_stage3_hart_pc_unit;
  localparam int          NH  = 2;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [NH-1:0]     hart_enable;
  logic [NH-1:0][31:0] pc;
  logic [NH-1:0]     hart_active;
  int checks = 0;
  int errors = 0;

  stage3_hart_pc_unit_if #(.NUM_HARTS(NH)) bus();

  stage3_hart_pc_unit #(.NUM_HARTS(NH), .RESET_PC(RPC), .PC_INCR(32'd4)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .hart_enable(hart_enable),
    .bus        (bus),
    .pc         (pc),
    .hart_active(hart_active)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  en;   logic rdy;
    logic bv; logic bh; logic [31:0] bpc;
    logic tv; logic th; logic [31:0] tpc;
    logic xv; logic xh; logic [31:0] xfpc;
    logic [31:0] xpc0; logic [31:0] xpc1; logic [1:0] xact;
  } vec_t;
  vec_t vec [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // en rdy | bv bh bpc | tv th tpc | exp: valid hart fetch_pc | pc0 pc1 active (after edge)
    vec[0]  = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0004, 32'h8000_0000, 2'b11};
    vec[1]  = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0004, 32'h8000_0004, 2'b11};
    vec[2]  = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0004, 32'h8000_0008, 32'h8000_0004, 2'b11};
    vec[3]  = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0004, 32'h8000_0008, 32'h8000_0008, 2'b11};
    vec[4]  = '{2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0008, 32'h8000_0008, 32'h8000_0008, 2'b11};
    vec[5]  = '{2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0008, 32'h8000_0008, 32'h8000_0008, 2'b11};
    vec[6]  = '{2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0008, 32'h8000_0008, 32'h8000_0008, 2'b11};
    vec[7]  = '{2'b11, 1'b1, 1'b1, 1'b0, 32'h8000_0103, 1'b1, 1'b1, 32'h8000_0200, 1'b0, 1'b0, 32'h8000_0008, 32'h8000_0100, 32'h8000_0200, 2'b11};
    vec[8]  = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0100, 32'h8000_0104, 32'h8000_0200, 2'b11};
    vec[9]  = '{2'b11, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 32'h8000_0104, 32'h8000_0108, 32'h20, 2'b11};
    vec[10] = '{2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFC, 32'h20, 2'b11};
    vec[11] = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFC, 32'h24, 2'b11};
    vec[12] = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h24, 2'b11};
    vec[13] = '{2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h24, 32'h0, 32'h28, 2'b01};
    vec[14] = '{2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4, 32'h28, 2'b01};
    vec[15] = '{2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h8, 32'h28, 2'b01};
    vec[16] = '{2'b01, 1'b1, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'hC, 32'h1000, 2'b01};
    vec[17] = '{2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hC, 32'h10, 32'h1000, 2'b00};
    vec[18] = '{2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000, 32'h10, 32'h1000, 2'b00};

    nRST = 1'b0; hart_enable = 2'b11;
    bus.fetch_ready = 1'b0;
    bus.br_valid = 1'b0; bus.br_hart = 1'b0; bus.br_pc = 32'h0;
    bus.trap_valid = 1'b0; bus.trap_hart = 1'b0; bus.trap_pc = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pc0", pc[0], RPC);
    chk("rst_pc1", pc[1], RPC);
    chk("rst_valid", 32'(bus.fetch_valid), 32'h0);
    chk("rst_hart", 32'(bus.fetch_hart), 32'h0);
    chk("rst_fpc", bus.fetch_pc, RPC);
    chk("rst_active", 32'(hart_active), 32'h0);

    nRST = 1'b1;
    #1;
    chk("rel_valid_early", 32'(bus.fetch_valid), 32'h0);
    @(posedge CLK); #1;
    chk("rel_active", 32'(hart_active), 32'h3);
    chk("rel_valid", 32'(bus.fetch_valid), 32'h1);
    chk("rel_hart", 32'(bus.fetch_hart), 32'h0);

    for (int i = 0; i < 19; i++) begin
      hart_enable     = vec[i].en;
      bus.fetch_ready = vec[i].rdy;
      bus.br_valid    = vec[i].bv;   bus.br_hart   = vec[i].bh; bus.br_pc   = vec[i].bpc;
      bus.trap_valid  = vec[i].tv;   bus.trap_hart = vec[i].th; bus.trap_pc = vec[i].tpc;
      #1;
      chk($sformatf("v%0d_valid", i), 32'(bus.fetch_valid), 32'(vec[i].xv));
      chk($sformatf("v%0d_hart", i), 32'(bus.fetch_hart), 32'(vec[i].xh));
      chk($sformatf("v%0d_fpc", i), bus.fetch_pc, vec[i].xfpc);
      @(posedge CLK); #1;
      chk($sformatf("v%0d_pc0", i), pc[0], vec[i].xpc0);
      chk($sformatf("v%0d_pc1", i), pc[1], vec[i].xpc1);
      chk($sformatf("v%0d_active", i), 32'(hart_active), 32'(vec[i].xact));
    end

    // reset during a live handshake with redirects pending
    hart_enable = 2'b11; bus.fetch_ready = 1'b1;
    bus.br_valid = 1'b1; bus.br_hart = 1'b0; bus.br_pc = 32'h40;
    bus.trap_valid = 1'b1; bus.trap_hart = 1'b1; bus.trap_pc = 32'h80;
    nRST = 1'b0;
    @(posedge CLK); #1;
    bus.br_valid = 1'b0; bus.trap_valid = 1'b0;
    #1;
    chk("mrst_pc0", pc[0], RPC);
    chk("mrst_pc1", pc[1], RPC);
    chk("mrst_active", 32'(hart_active), 32'h0);
    chk("mrst_valid", 32'(bus.fetch_valid), 32'h0);
    chk("mrst_hart", 32'(bus.fetch_hart), 32'h0);
    chk("mrst_fpc", bus.fetch_pc, RPC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage3_hart_pc_unit.md
Name: stage3_hart_pc_unit

Overview:
- Per-hart program counter unit for the 3-stage pipeline; generalises the single PC/NPC pair to NUM_HARTS independent PC registers.
- Each cycle it selects one active hart round-robin and presents that hart's PC to fetch through a valid/ready handshake.
- Advances the selected PC sequentially on acceptance.
- Applies branch/jump redirects and trap redirects per hart with fixed priority.

Parameters:
- NUM_HARTS, 2, number of hardware threads (1..16).
- RESET_PC, 32'h8000_0000, PC value of every hart after reset.
- PC_INCR, 4, sequential increment applied on fetch acceptance.
- HART_W (localparam), max(1,$clog2(NUM_HARTS)), width of hart-id fields.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  synchronous active-low reset.
- hart_enable  input  NUM_HARTS  per-hart run request.
- fetch_valid  output  1  fetch_pc/fetch_hart are valid.
- fetch_ready  input  1  fetch accepts the current PC.
- fetch_pc  output  32  PC of the selected hart.
- fetch_hart  output  HART_W  id of the selected hart.
- br_valid  input  1  branch/jump redirect from execute.
- br_hart  input  HART_W  target hart of the branch redirect.
- br_pc  input  32  branch/jump target.
- trap_valid  input  1  trap/xRET redirect from the CSR/priv unit.
- trap_hart  input  HART_W  target hart of the trap redirect.
- trap_pc  input  32  trap vector / return address.
- pc  output  NUM_HARTS x 32  current PC of every hart (word_t packed array).
- hart_active  output  NUM_HARTS  per-hart FSM state (1 = ACTIVE).

Behaviour:
- Per-hart FSM, states PARKED and ACTIVE.
  - PARKED -> ACTIVE when hart_enable[h]=1 at the clock edge.
  - ACTIVE -> PARKED when hart_enable[h]=0.
  - The PC is preserved across PARKED.
- Enable takes effect one cycle after it is sampled: hart_active is registered.
- Reset, synchronous, when nRST=0 at the edge:
  - all pc[h] = RESET_PC
  - all harts PARKED
  - rr_ptr = 0
  - resulting outputs: fetch_valid=0, fetch_pc=RESET_PC, fetch_hart=0, hart_active=0.
- Reset has priority over all other inputs, including a mid-handshake fetch and redirects.
- Eligibility of hart h: hart_active[h]=1, and not (br_valid and br_hart==h), and not (trap_valid and trap_hart==h).
  - Redirected harts are masked in the same cycle so a stale PC is never issued.
- Selection:
  - Choose the first eligible hart scanning cyclically from rr_ptr upward, wrapping at NUM_HARTS-1 -> 0.
  - fetch_valid=1 iff at least one hart is eligible.
  - When no hart is eligible: fetch_valid=0 and fetch_hart=rr_ptr.
  - fetch_pc=pc[fetch_hart]; this path is purely combinational from registers and redirect inputs.
- Handshake:
  - Accepted iff fetch_valid and fetch_ready.
  - On acceptance: pc[sel] <= pc[sel] + PC_INCR, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000), and rr_ptr <= (sel+1) mod NUM_HARTS.
  - Without acceptance: rr_ptr and all PCs hold.
  - fetch_valid may fall without acceptance (hart disabled or redirected); fetch has no stability requirement on us.
- Redirects:
  - br_valid: pc[br_hart] <= {br_pc[31:2],2'b00}.
  - trap_valid: pc[trap_hart] <= {trap_pc[31:2],2'b00}.
  - If both target the same hart, trap wins and the branch is dropped.
  - If they target different harts, both apply.
  - Redirects apply regardless of FSM state, so a PARKED hart may be redirected.
  - Hart ids >= NUM_HARTS are ignored.
- Priority per hart per cycle: reset > trap > branch > sequential increment > hold.
- NUM_HARTS=1:
  - rr_ptr is constant 0 and fetch_hart=0.
  - The unit degenerates to a single PC with redirect masking.

Test Plan:
- Reset with nRST=0 for 2 cycles and hart_enable=2'b11 → pc[0]=pc[1]=0x8000_0000 and fetch_valid=0. After release, one cycle later fetch_valid=1 with fetch_hart=0.
- Both harts enabled, fetch_ready=1 for 4 cycles → fetch sequence h0@0x8000_0000, h1@0x8000_0000, h0@0x8000_0004, h1@0x8000_0004.
- fetch_ready=0 for 3 cycles with both harts active → fetch_hart, fetch_pc, rr_ptr and all PCs unchanged throughout.
- Collision case:
  - stimulus: h0 selected, and in the same cycle br_valid=1, br_hart=0, br_pc=0x8000_0103; trap_valid=1, trap_hart=1, trap_pc=0x8000_0200
  - required: fetch_valid=0 that cycle, no increment, next pc[0]=0x8000_0100, pc[1]=0x8000_0200.
- Same-hart conflict: br and trap both target hart 1 (br_pc=0x10, trap_pc=0x20) → pc[1]=0x20.
- Wrap and park:
  - stimulus: pc[0] set to 0xFFFF_FFFC via trap, then accepted → pc[0]=0x0000_0000.
  - stimulus: hart_enable=2'b01 → hart 1 parks with its PC held; only hart 0 is issued thereafter.
